// File: rtl/packet_router_stats_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : packet_router_stats_regbank
//  Description : Event counter bank for the packet router with an AXI4-Lite
//                slave (read counters/INFO, write-1-to-clear CLEAR register).
//                Define PACKET_ROUTER_STATS_SATURATE_EN for saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_router_stats_regbank #(
    parameter int NUM_COUNTERS = 3,
    parameter int CNT_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_COUNTERS-1:0] inc,
    input  logic [31:0]             s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [31:0]             s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    input  logic [31:0]             s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [31:0]             s_axil_wdata,
    input  logic [3:0]              s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready
);

    localparam logic [ADDR_WIDTH-1:0] C_CNT_END    = ADDR_WIDTH'(8'h80);
    localparam logic [ADDR_WIDTH-1:0] C_INFO_ADDR  = ADDR_WIDTH'(8'h80);
    localparam logic [ADDR_WIDTH-1:0] C_CLEAR_ADDR = ADDR_WIDTH'(8'h84);
    localparam logic [1:0]            C_OKAY       = 2'b00;
    localparam logic [1:0]            C_SLVERR     = 2'b10;
    localparam logic [31:0]           C_INFO_VAL   = {16'(CNT_WIDTH), 16'(NUM_COUNTERS)};

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;
    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;

    rd_state_t               rd_state_q, rd_state_d;
    wr_state_t               wr_state_q, wr_state_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [CNT_WIDTH-1:0]    cnt_q [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_COUNTERS];

    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [4:0]              rd_idx;
    logic                    rd_hit;
    logic [31:0]             rd_data_sel;
    logic [1:0]              rd_resp_sel;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    wr_hs;
    logic                    wr_clear_hit;
    logic                    unused_bits;

    assign unused_bits = ^{s_axil_araddr, s_axil_awaddr, s_axil_wdata, s_axil_wstrb};

    // Read decode: counters occupy 0x00..0x7C, INFO and CLEAR sit above them
    always_comb begin
        rd_addr     = s_axil_araddr[ADDR_WIDTH-1:0];
        rd_idx      = rd_addr[6:2];
        rd_hit      = 1'b0;
        rd_data_sel = '0;
        rd_resp_sel = C_SLVERR;
        if (rd_addr[1:0] == 2'b00) begin
            if (rd_addr < C_CNT_END) begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    if (rd_idx == 5'(i)) begin
                        rd_hit      = 1'b1;
                        rd_data_sel = 32'(cnt_q[i]);
                    end
                end
                if (rd_hit) begin
                    rd_resp_sel = C_OKAY;
                end else begin
                    rd_data_sel = '0;
                end
            end else if (rd_addr == C_INFO_ADDR) begin
                rd_data_sel = C_INFO_VAL;
                rd_resp_sel = C_OKAY;
            end else if (rd_addr == C_CLEAR_ADDR) begin
                rd_resp_sel = C_OKAY;
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axil_arvalid) begin
                    rdata_d    = rd_data_sel;
                    rresp_d    = rd_resp_sel;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign s_axil_arready = (rd_state_q == R_IDLE);
    assign s_axil_rvalid  = (rd_state_q == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    // AW and W are only ever accepted together in the same cycle
    assign wr_addr      = s_axil_awaddr[ADDR_WIDTH-1:0];
    assign wr_hs        = (wr_state_q == W_IDLE) && s_axil_awvalid && s_axil_wvalid;
    assign wr_clear_hit = wr_hs && (wr_addr == C_CLEAR_ADDR);

    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_hs) begin
                    bresp_d    = wr_clear_hit ? C_OKAY : C_SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign s_axil_awready = wr_hs;
    assign s_axil_wready  = wr_hs;
    assign s_axil_bvalid  = (wr_state_q == W_RESP);
    assign s_axil_bresp   = bresp_q;

    // Clear has priority over a coincident increment
    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_clear_hit && s_axil_wdata[i] && s_axil_wstrb[i/8]) begin
                cnt_d[i] = '0;
            end else if (inc[i]) begin
`ifdef PACKET_ROUTER_STATS_SATURATE_EN
                if (cnt_q[i] != {CNT_WIDTH{1'b1}}) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
`else
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rdata_q    <= '0;
            rresp_q    <= C_OKAY;
            bresp_q    <= C_OKAY;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            bresp_q    <= bresp_d;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
`default_nettype wire
